sdram_sweep_checker: RTL

SDRAM_SWEEP_CHECKER -- requirements
Module: sdram_sweep_checker

---
 rtl/sdram_test_pkg.sv | 32 +++
 rtl/sweep_pattern_gen.sv | 48 ++++
 rtl/sdram_sweep_checker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_test_pkg
// Purpose  : Shared FSM encodings, pattern codes and LFSR definition for the
//            SDRAM address-sweep checker.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_test_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WR_REQ  = 3'd1;
    localparam state_t c_ST_RD_REQ  = 3'd2;
    localparam state_t c_ST_RD_WAIT = 3'd3;
    localparam state_t c_ST_FINISH  = 3'd4;

    localparam logic [1:0] c_PAT_ADDR    = 2'd0;
    localparam logic [1:0] c_PAT_INV     = 2'd1;
    localparam logic [1:0] c_PAT_CHECKER = 2'd2;
    localparam logic [1:0] c_PAT_LFSR    = 2'd3;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & c_LFSR_TAPS), s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : sweep_pattern_gen
// Purpose  : Produces the data word for the current sweep address; the LFSR
//            pattern advances on step and restarts on seed.
// Revision : 1.0 - initial release
// ============================================================================
module sweep_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [15:0]       addr,
    input  logic              seed,
    input  logic              step,
    output logic [DATA_W-1:0] word
);

    logic [15:0] r_lfsr;
    logic [15:0] w_pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (seed) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    always_comb begin
        w_pat = 16'h0000;
        case (sel)
            c_PAT_ADDR:    w_pat = addr;
            c_PAT_INV:     w_pat = ~addr;
            c_PAT_CHECKER: w_pat = addr[0] ? 16'h5555 : 16'hAAAA;
            default:       w_pat = r_lfsr;
        endcase
    end

    assign word = DATA_W'(w_pat);

endmodule
`default_nettype wire

// File: rtl/sdram_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : sdram_sweep_checker
// Purpose  : Writes a data pattern over [0..last_addr], reads it back and
//            reports mismatches, read timeouts and the first failing address.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_sweep_checker
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout_flag
);

    localparam int                  c_WAIT_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(RD_TIMEOUT);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last;
    logic [ADDR_W-1:0]   r_first_err;
    logic [1:0]          r_sel;
    logic [DATA_W-1:0]   r_exp;
    logic [c_WAIT_W-1:0] r_wait;
    logic [15:0]         r_err_count;
    logic                r_timeout;
    logic                r_pass;

    logic                w_valid;
    logic                w_rw;
    logic                w_accept;
    logic                w_last;
    logic                w_seed;
    logic                w_step;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                w_rd_done;
    logic                w_mismatch;
    logic                w_pass_now;
    logic [DATA_W-1:0]   w_word;

    // Assert asynchronously, release two clocks later in the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_valid    = (r_state == c_ST_WR_REQ) || (r_state == c_ST_RD_REQ);
    assign w_rw       = (r_state == c_ST_WR_REQ);
    assign w_accept   = w_valid && !mem_busy;
    assign w_last     = (r_addr == r_last);
    assign w_seed     = ((r_state == c_ST_IDLE) && start) || (w_rw && w_accept && w_last);
    assign w_step     = w_accept && !w_seed;
    assign w_wait_inc = r_wait + c_WAIT_W'(1);
    assign w_rd_done  = mem_rdata_valid || (w_wait_inc == c_TIMEOUT);
    assign w_mismatch = !mem_rdata_valid || (mem_rdata != r_exp);
    assign w_pass_now = (r_err_count == 16'h0000) && !r_timeout;

    sweep_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .clk   (clk),
        .rst_n (w_rst_n),
        .sel   (r_sel),
        .addr  (16'(r_addr)),
        .seed  (w_seed),
        .step  (w_step),
        .word  (w_word)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_last      <= '0;
            r_first_err <= '0;
            r_sel       <= 2'b00;
            r_exp       <= '0;
            r_wait      <= '0;
            r_err_count <= 16'h0000;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state     <= c_ST_WR_REQ;
                        r_addr      <= '0;
                        r_last      <= last_addr;
                        r_sel       <= pattern_sel;
                        r_first_err <= '0;
                        r_err_count <= 16'h0000;
                        r_timeout   <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                c_ST_WR_REQ: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_addr  <= '0;
                            r_state <= c_ST_RD_REQ;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                c_ST_RD_REQ: begin
                    // The generator steps on this same edge, so snapshot the word now.
                    if (w_accept) begin
                        r_exp   <= w_word;
                        r_wait  <= '0;
                        r_state <= c_ST_RD_WAIT;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (w_rd_done) begin
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'd1;
                            end
                            if (r_err_count == 16'h0000) begin
                                r_first_err <= r_addr;
                            end
                        end
                        if (!mem_rdata_valid) begin
                            r_timeout <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= c_ST_RD_REQ;
                        end
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                c_ST_FINISH: begin
                    r_pass  <= w_pass_now;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr       = r_addr;
    assign mem_wdata      = w_rw ? w_word : '0;
    assign mem_rw         = w_rw;
    assign mem_valid      = w_valid;
    assign busy           = (r_state != c_ST_IDLE);
    assign done           = (r_state == c_ST_FINISH);
    assign pass           = done ? w_pass_now : r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;
    assign timeout_flag   = r_timeout;

endmodule
`default_nettype wire
